// File: rtl/bus_arbiter_8.sv
// 8-way round-robin bus arbiter with a per-owner hold limit.
// Outputs come straight from flops; req only feeds next-state logic.
module bus_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic [7:0] hold_cnt
);

  typedef enum logic {StIdle, StOwn} state_e;

  // Last legal hold_cnt value before forced re-arbitration.
  localparam logic [7:0] MaxCnt = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [7:0] grant_q, grant_d;
  logic [7:0] hold_q, hold_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       release_own;

  // Round-robin search: first set req bit starting just above the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = last_q + 3'(k + 1);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Owner gives up the bus when it drops its request or hits the hold limit.
  always_comb begin
    release_own = !req[sel_q] || (hold_q == MaxCnt);
  end

  // Next-state: grant on any winning search, otherwise keep counting or go idle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StOwn;
          sel_d   = win_idx;
          last_d  = win_idx;
          grant_d = 8'b1 << win_idx;
          hold_d  = 8'd0;
        end
      end
      StOwn: begin
        if (release_own) begin
          if (win_found) begin
            // Covers hand-over and timeout re-grant to a lone requester.
            sel_d   = win_idx;
            last_d  = win_idx;
            grant_d = 8'b1 << win_idx;
            hold_d  = 8'd0;
          end else begin
            // sel keeps the previous owner so the bus mux stays stable.
            state_d = StIdle;
            grant_d = 8'd0;
            hold_d  = 8'd0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 8'd0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State registers; last owner resets to 7 so the first search starts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      grant_q <= 8'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  assign sel      = sel_q;
  assign grant    = grant_q;
  assign busy     = (state_q == StOwn);
  assign hold_cnt = hold_q;

endmodule
